// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk -- PRBS word generator plus a self-synchronising PRBS checker
// with lock detection and a saturating bit-error counter.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_mode            polynomial: 00 PRBS7, 01 PRBS15, 10 PRBS23, 11 PRBS31
//   i_gen_en          produce one P_DW-bit word this cycle
//   i_inj_err         invert bit 0 of the word produced this cycle
//   o_gen_data/valid  generated word (bit P_DW-1 oldest, bit 0 newest)
//   i_chk_data/valid  received word, same bit order
//   i_clr             synchronous clear of o_err_cnt
//   o_locked          checker locked to the incoming sequence
//   o_err_word        one-cycle pulse per errored word while locked
//   o_err_cnt         saturating count of mismatched bits while locked
//
// Lock FSM
//   state     | meaning
//   ST_UNLOCK | hunting; r_run counts down clean words still needed to lock
//   ST_LOCKED | locked; r_run counts down errored words still tolerated

module prbs_gen_chk #(
   parameter int          P_DW         = 32,
   parameter logic [30:0] P_SEED       = 31'h0000A076,
   parameter int          P_LOCK_CNT   = 16,
   parameter int          P_UNLOCK_CNT = 4
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [1:0]      i_mode,
   input  logic            i_gen_en,
   input  logic            i_inj_err,
   output logic [P_DW-1:0] o_gen_data,
   output logic            o_gen_valid,
   input  logic [P_DW-1:0] i_chk_data,
   input  logic            i_chk_valid,
   input  logic            i_clr,
   output logic            o_locked,
   output logic            o_err_word,
   output logic [31:0]     o_err_cnt
);

   localparam int LP_MAX_RUN = (P_LOCK_CNT > P_UNLOCK_CNT) ? P_LOCK_CNT : P_UNLOCK_CNT;
   localparam int LP_CW      = $clog2(LP_MAX_RUN + 1);
   localparam int LP_PW      = $clog2(P_DW + 1);

   localparam logic [LP_CW-1:0] LP_LOCK_LD   = LP_CW'(P_LOCK_CNT - 1);
   localparam logic [LP_CW-1:0] LP_UNLOCK_LD = LP_CW'(P_UNLOCK_CNT - 1);

   // Reset behaves as if PRBS31 were selected; any other i_mode is picked up
   // as a mode change on the first clock after reset and reseeds properly.
   localparam logic [1:0] LP_RST_MODE = 2'b11;

   typedef enum logic {ST_UNLOCK, ST_LOCKED} state_t;

   // history index of x^N term (N-1)
   function automatic logic [4:0] f_tap_hi(input logic [1:0] mode);
      case (mode)
         2'b00:   return 5'd6;
         2'b01:   return 5'd14;
         2'b10:   return 5'd22;
         default: return 5'd30;
      endcase
   endfunction

   // history index of x^M term (M-1)
   function automatic logic [4:0] f_tap_lo(input logic [1:0] mode);
      case (mode)
         2'b00:   return 5'd5;
         2'b01:   return 5'd13;
         2'b10:   return 5'd17;
         default: return 5'd27;
      endcase
   endfunction

   function automatic logic [30:0] f_mask(input logic [1:0] mode);
      case (mode)
         2'b00:   return 31'h0000007F;
         2'b01:   return 31'h00007FFF;
         2'b10:   return 31'h007FFFFF;
         default: return 31'h7FFFFFFF;
      endcase
   endfunction

   // an all-zero seed would lock the LFSR, so it is replaced by all-ones
   function automatic logic [30:0] f_seed(input logic [1:0] mode);
      logic [30:0] s;
      s = P_SEED & f_mask(mode);
      if (s == '0) begin
         s = f_mask(mode);
      end
      return s;
   endfunction

   logic [1:0]       r_mode;
   logic [30:0]      r_hist;
   logic [30:0]      r_rx;
   state_t           r_state;
   logic [LP_CW-1:0] r_run;

   logic             w_mode_chg;
   logic [4:0]       w_thi;
   logic [4:0]       w_tlo;
   logic [30:0]      w_hist_nxt;
   logic [P_DW-1:0]  w_gen_word;
   logic             w_hist_zero;
   logic [30:0]      w_rx_nxt;
   logic [P_DW-1:0]  w_mism;
   logic [LP_PW-1:0] w_pop;
   logic             w_word_err;
   logic [32:0]      w_cnt_sum;
   logic [31:0]      w_cnt_sat;

   assign w_mode_chg  = (i_mode != r_mode);
   assign w_thi       = f_tap_hi(r_mode);
   assign w_tlo       = f_tap_lo(r_mode);
   assign w_hist_zero = ((r_hist & f_mask(r_mode)) == '0);

   // Unroll P_DW LFSR steps; oldest bit lands in the MSB of the word.
   always_comb begin
      w_hist_nxt = r_hist;
      w_gen_word = '0;
      for (int i = 0; i < P_DW; i++) begin
         w_gen_word[P_DW-1-i] = w_hist_nxt[w_thi] ^ w_hist_nxt[w_tlo];
         w_hist_nxt           = {w_hist_nxt[29:0], w_gen_word[P_DW-1-i]};
      end
   end

   // Each received bit is predicted from earlier received bits, so the
   // checker needs no seed and resynchronises on its own.
   always_comb begin
      w_rx_nxt = r_rx;
      w_mism   = '0;
      for (int i = 0; i < P_DW; i++) begin
         w_mism[P_DW-1-i] = i_chk_data[P_DW-1-i] ^ w_rx_nxt[w_thi] ^ w_rx_nxt[w_tlo];
         w_rx_nxt         = {w_rx_nxt[29:0], i_chk_data[P_DW-1-i]};
      end
   end

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < P_DW; i++) begin
         w_pop = w_pop + LP_PW'(w_mism[i]);
      end
   end

   assign w_word_err = |w_mism;
   assign w_cnt_sum  = {1'b0, o_err_cnt} + 33'(w_pop);
   assign w_cnt_sat  = w_cnt_sum[32] ? 32'hFFFFFFFF : w_cnt_sum[31:0];

   // Generator
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mode      <= LP_RST_MODE;
         r_hist      <= f_seed(LP_RST_MODE);
         o_gen_data  <= '0;
         o_gen_valid <= 1'b0;
      end else begin
         r_mode      <= i_mode;
         o_gen_valid <= 1'b0;
         if (w_mode_chg) begin
            r_hist <= f_seed(i_mode);
         end else if (i_gen_en) begin
            if (w_hist_zero) begin
               r_hist <= f_seed(r_mode);
            end else begin
               r_hist      <= w_hist_nxt;
               o_gen_data  <= {w_gen_word[P_DW-1:1], w_gen_word[0] ^ i_inj_err};
               o_gen_valid <= 1'b1;
            end
         end
      end
   end

   // Checker history and lock FSM
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_UNLOCK;
         r_run      <= LP_LOCK_LD;
         r_rx       <= '0;
         o_locked   <= 1'b0;
         o_err_word <= 1'b0;
         o_err_cnt  <= '0;
      end else begin
         o_err_word <= 1'b0;
         if (i_clr) begin
            o_err_cnt <= '0;
         end
         if (w_mode_chg) begin
            r_state  <= ST_UNLOCK;
            r_run    <= LP_LOCK_LD;
            r_rx     <= '0;
            o_locked <= 1'b0;
         end else if (i_chk_valid) begin
            r_rx <= w_rx_nxt;
            case (r_state)
               ST_UNLOCK: begin
                  if (w_word_err) begin
                     r_run <= LP_LOCK_LD;
                  end else if (r_run == '0) begin
                     r_state  <= ST_LOCKED;
                     o_locked <= 1'b1;
                     r_run    <= LP_UNLOCK_LD;
                  end else begin
                     r_run <= r_run - LP_CW'(1);
                  end
               end
               ST_LOCKED: begin
                  if (w_word_err) begin
                     o_err_word <= 1'b1;
                     // clear has priority over counting this word
                     if (!i_clr) begin
                        o_err_cnt <= w_cnt_sat;
                     end
                     if (r_run == '0) begin
                        r_state  <= ST_UNLOCK;
                        o_locked <= 1'b0;
                        r_run    <= LP_LOCK_LD;
                     end else begin
                        r_run <= r_run - LP_CW'(1);
                     end
                  end else begin
                     r_run <= LP_UNLOCK_LD;
                  end
               end
               default: begin
                  r_state  <= ST_UNLOCK;
                  o_locked <= 1'b0;
                  r_run    <= LP_LOCK_LD;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prbs_gen_chk.sv
module tb_prbs_gen_chk;

   localparam int          DW     = 32;
   localparam logic [30:0] SEED   = 31'h0000A076;
   localparam int          LOCK   = 16;
   localparam int          UNLOCK = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [1:0]    mode;
   logic          gen_en, inj_err, clr, inv;
   logic [DW-1:0] gen_data;
   logic          gen_valid;
   logic [DW-1:0] chk_data;
   logic          chk_valid;
   logic          locked, err_word;
   logic [31:0]   err_cnt;

   assign chk_data  = gen_data ^ {DW{inv}};
   assign chk_valid = gen_valid;

   logic [1:0]  mode8;
   logic        gen_en8;
   logic        inj8;
   logic [7:0]  gen_data8;
   logic        gen_valid8;
   logic        clr8;
   logic        locked8, err_word8;
   logic [31:0] err_cnt8;

   prbs_gen_chk #(.P_DW(DW), .P_SEED(SEED), .P_LOCK_CNT(LOCK), .P_UNLOCK_CNT(UNLOCK)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_gen_en(gen_en), .i_inj_err(inj_err),
      .o_gen_data(gen_data), .o_gen_valid(gen_valid), .i_chk_data(chk_data),
      .i_chk_valid(chk_valid), .i_clr(clr), .o_locked(locked), .o_err_word(err_word),
      .o_err_cnt(err_cnt));

   prbs_gen_chk #(.P_DW(8), .P_SEED(SEED), .P_LOCK_CNT(LOCK), .P_UNLOCK_CNT(UNLOCK)) u_dut8 (
      .i_clk(clk), .i_rst(rst), .i_mode(mode8), .i_gen_en(gen_en8), .i_inj_err(inj8),
      .o_gen_data(gen_data8), .o_gen_valid(gen_valid8), .i_chk_data(gen_data8),
      .i_chk_valid(gen_valid8), .i_clr(clr8), .o_locked(locked8), .o_err_word(err_word8),
      .o_err_cnt(err_cnt8));

   int checks = 0;
   int errors = 0;

   // Reference model: bit streams as queues, recurrence s[k] = s[k-N] ^ s[k-M]
   bit            gq[$];
   bit            cq[$];
   int            g_n, g_m, c_n, c_m;
   logic [1:0]    m_mode;
   logic [DW-1:0] m_gen_word;
   bit            m_gen_valid;
   bit            m_lock;
   int            m_good, m_bad;
   logic [31:0]   m_err_cnt;
   bit            m_err_word;

   function automatic void taps(input logic [1:0] md, output int n, output int m);
      case (md)
         2'b00:   begin n = 7;  m = 6;  end
         2'b01:   begin n = 15; m = 14; end
         2'b10:   begin n = 23; m = 18; end
         default: begin n = 31; m = 28; end
      endcase
   endfunction

   function automatic void gm_seed(input logic [1:0] md);
      longint mask, s;
      taps(md, g_n, g_m);
      mask = (longint'(1) << g_n) - 1;
      s = longint'(SEED) & mask;
      if (s == 0) s = mask;
      gq.delete();
      for (int j = 0; j < g_n; j++) gq.push_back(s[g_n-1-j]);
   endfunction

   function automatic logic [63:0] gm_word(input int dw);
      logic [63:0] w;
      int k;
      bit b;
      w = '0;
      for (int i = 0; i < dw; i++) begin
         k = gq.size();
         b = gq[k-g_n] ^ gq[k-g_m];
         gq.push_back(b);
         w[dw-1-i] = b;
      end
      while (gq.size() > 80) void'(gq.pop_front());
      return w;
   endfunction

   function automatic void cm_reset(input logic [1:0] md);
      taps(md, c_n, c_m);
      cq.delete();
      repeat (31) cq.push_back(1'b0);
   endfunction

   function automatic int cm_word(input logic [63:0] d, input int dw);
      int pop, k;
      bit b, e;
      pop = 0;
      for (int i = 0; i < dw; i++) begin
         b = d[dw-1-i];
         k = cq.size();
         e = cq[k-c_n] ^ cq[k-c_m];
         if (b != e) pop++;
         cq.push_back(b);
      end
      while (cq.size() > 80) void'(cq.pop_front());
      return pop;
   endfunction

   function automatic void model_reset();
      m_mode = 2'b11;
      gm_seed(2'b11);
      cm_reset(2'b11);
      m_gen_word = '0;
      m_gen_valid = 0;
      m_lock = 0;
      m_good = 0;
      m_bad = 0;
      m_err_cnt = '0;
      m_err_word = 0;
   endfunction

   // One clock of DUT and model; outputs are sampled 1 time unit after the edge.
   task automatic cycle(input bit en, input bit ij, input bit iv, input bit cl, input logic [1:0] md);
      bit            cv, chg;
      logic [DW-1:0] cd;
      logic [63:0]   w;
      int            pop;
      longint        t;
      gen_en = en; inj_err = ij; inv = iv; clr = cl; mode = md;
      cv  = m_gen_valid;
      cd  = m_gen_word ^ {DW{iv}};
      chg = (md != m_mode);
      @(posedge clk);
      #1;
      m_err_word = 0;
      if (chg) begin
         m_mode = md;
         gm_seed(md);
         cm_reset(md);
         m_gen_valid = 0;
         m_lock = 0;
         m_good = 0;
         m_bad = 0;
      end else begin
         if (en) begin
            w = gm_word(DW);
            m_gen_word = w[DW-1:0];
            m_gen_word[0] = m_gen_word[0] ^ ij;
            m_gen_valid = 1;
         end else begin
            m_gen_valid = 0;
         end
         if (cv) begin
            pop = cm_word({32'h0, cd}, DW);
            if (m_lock) begin
               if (pop > 0) begin
                  m_err_word = 1;
                  t = longint'(m_err_cnt) + pop;
                  if (t > 64'hFFFFFFFF) t = 64'hFFFFFFFF;
                  m_err_cnt = t[31:0];
                  m_bad++;
                  if (m_bad >= UNLOCK) begin
                     m_lock = 0;
                     m_bad = 0;
                     m_good = 0;
                  end
               end else begin
                  m_bad = 0;
               end
            end else begin
               if (pop == 0) begin
                  m_good++;
                  if (m_good >= LOCK) begin
                     m_lock = 1;
                     m_good = 0;
                     m_bad = 0;
                  end
               end else begin
                  m_good = 0;
               end
            end
         end
      end
      if (cl) m_err_cnt = '0;
   endtask

   task automatic test_reset();
      rst = 1; mode = 2'b11; gen_en = 0; inj_err = 0; clr = 0; inv = 0;
      mode8 = 2'b00; gen_en8 = 0; inj8 = 0; clr8 = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (gen_data !== '0) begin errors++; $display("FAIL rst_gen_data got %h exp 0", gen_data); end
      checks++; if (gen_valid !== 1'b0) begin errors++; $display("FAIL rst_gen_valid got %b exp 0", gen_valid); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b exp 0", locked); end
      checks++; if (err_word !== 1'b0) begin errors++; $display("FAIL rst_err_word got %b exp 0", err_word); end
      checks++; if (err_cnt !== 32'h0) begin errors++; $display("FAIL rst_err_cnt got %h exp 0", err_cnt); end
      rst = 0;
      model_reset();
      cycle(0, 0, 0, 0, 2'b11);
      checks++; if (gen_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid got %b exp 0", gen_valid); end
   endtask

   task automatic test_lock();
      int rise;
      rise = -1;
      for (int i = 0; i < 40; i++) begin
         cycle(1, 0, 0, 0, 2'b11);
         checks++; if (gen_data !== m_gen_word || gen_valid !== 1'b1) begin
            errors++; $display("FAIL lock_gen cyc %0d got %h/%b exp %h/1", i, gen_data, gen_valid, m_gen_word);
         end
         checks++; if (locked !== m_lock) begin
            errors++; $display("FAIL lock_state cyc %0d got %b exp %b", i, locked, m_lock);
         end
         if (locked === 1'b1 && rise < 0) rise = i;
      end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_final got %b exp 1", locked); end
      checks++; if (err_cnt !== 32'h0) begin errors++; $display("FAIL lock_err_cnt got %0d exp 0", err_cnt); end
      $display("lock rose at cycle %0d", rise);
   endtask

   task automatic test_inject();
      int pulses;
      pulses = 0;
      cycle(1, 0, 0, 1, 2'b11);
      cycle(1, 1, 0, 0, 2'b11);
      checks++; if (gen_data !== m_gen_word) begin
         errors++; $display("FAIL inj_word got %h exp %h", gen_data, m_gen_word);
      end
      for (int i = 0; i < 6; i++) begin
         cycle(1, 0, 0, 0, 2'b11);
         if (err_word === 1'b1) pulses++;
         checks++; if (err_word !== m_err_word) begin
            errors++; $display("FAIL inj_err_word cyc %0d got %b exp %b", i, err_word, m_err_word);
         end
      end
      checks++; if (err_cnt !== 32'd3) begin errors++; $display("FAIL inj_err_cnt got %0d exp 3", err_cnt); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL inj_locked got %b exp 1", locked); end
      checks++; if (pulses < 1 || pulses > 2) begin errors++; $display("FAIL inj_pulses got %0d exp 1..2", pulses); end
   endtask

   task automatic test_clr_coincident();
      cycle(1, 1, 0, 0, 2'b11);
      cycle(1, 0, 0, 1, 2'b11);
      checks++; if (err_word !== 1'b1) begin errors++; $display("FAIL clr_err_word got %b exp 1", err_word); end
      checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL clr_wins got %0d exp 0", err_cnt); end
      repeat (4) cycle(1, 0, 0, 0, 2'b11);
      checks++; if (err_cnt !== 32'd2) begin errors++; $display("FAIL clr_echoes got %0d exp 2", err_cnt); end
      checks++; if (err_cnt !== m_err_cnt) begin errors++; $display("FAIL clr_model got %0d exp %0d", err_cnt, m_err_cnt); end
   endtask

   task automatic test_invert();
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL inv_pre_locked got %b exp 1", locked); end
      for (int i = 0; i < 4; i++) begin
         cycle(1, 0, 1, 0, 2'b11);
         checks++; if (locked !== ((i < 3) ? 1'b1 : 1'b0)) begin
            errors++; $display("FAIL inv_locked word %0d got %b exp %b", i, locked, (i < 3));
         end
         checks++; if (err_cnt !== m_err_cnt) begin
            errors++; $display("FAIL inv_err_cnt word %0d got %0d exp %0d", i, err_cnt, m_err_cnt);
         end
      end
      for (int i = 0; i < 30; i++) begin
         cycle(1, 0, 0, 0, 2'b11);
         checks++; if (locked !== m_lock || err_cnt !== m_err_cnt) begin
            errors++; $display("FAIL inv_recover cyc %0d got %b/%0d exp %b/%0d", i, locked, err_cnt, m_lock, m_err_cnt);
         end
      end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL inv_relock got %b exp 1", locked); end
   endtask

   task automatic test_mode_change();
      logic [31:0] cnt0;
      cnt0 = m_err_cnt;
      cycle(0, 0, 0, 0, 2'b01);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mode_unlock got %b exp 0", locked); end
      checks++; if (err_cnt !== cnt0) begin errors++; $display("FAIL mode_cnt_hold got %0d exp %0d", err_cnt, cnt0); end
      for (int i = 0; i < 40; i++) begin
         cycle(1, 0, 0, 0, 2'b01);
         checks++; if (gen_data !== m_gen_word || locked !== m_lock) begin
            errors++; $display("FAIL mode15 cyc %0d got %h/%b exp %h/%b", i, gen_data, locked, m_gen_word, m_lock);
         end
      end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mode_relock got %b exp 1", locked); end
      checks++; if (err_cnt !== cnt0) begin errors++; $display("FAIL mode_cnt_after got %0d exp %0d", err_cnt, cnt0); end
      cycle(0, 0, 0, 0, 2'b11);
      repeat (25) cycle(1, 0, 0, 0, 2'b11);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mode_back_lock got %b exp 1", locked); end
   endtask

   task automatic test_random();
      bit en, ij, iv, cl;
      logic [1:0] md;
      md = 2'b11;
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 3) != 0);
         ij = ($urandom_range(0, 19) == 0);
         iv = ($urandom_range(0, 99) == 0);
         cl = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 149) == 0) md = 2'($urandom_range(0, 3));
         cycle(en, ij, iv, cl, md);
         checks++; if (gen_valid !== m_gen_valid || gen_data !== m_gen_word) begin
            errors++; $display("FAIL rnd_gen cyc %0d got %h/%b exp %h/%b", i, gen_data, gen_valid, m_gen_word, m_gen_valid);
         end
         checks++; if (locked !== m_lock || err_word !== m_err_word || err_cnt !== m_err_cnt) begin
            errors++; $display("FAIL rnd_chk cyc %0d got %b/%b/%0d exp %b/%b/%0d", i, locked, err_word, err_cnt, m_lock, m_err_word, m_err_cnt);
         end
      end
   endtask

   task automatic test_reset_mid();
      cycle(0, 0, 0, 0, 2'b11);
      repeat (20) cycle(1, 0, 0, 0, 2'b11);
      rst = 1;
      #1;
      checks++; if (gen_data !== '0 || gen_valid !== 1'b0) begin
         errors++; $display("FAIL mid_rst_gen got %h/%b exp 0/0", gen_data, gen_valid);
      end
      checks++; if (locked !== 1'b0 || err_word !== 1'b0 || err_cnt !== 32'h0) begin
         errors++; $display("FAIL mid_rst_chk got %b/%b/%0d exp 0/0/0", locked, err_word, err_cnt);
      end
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
      cycle(1, 0, 0, 0, 2'b11);
      checks++; if (gen_data !== m_gen_word || gen_valid !== 1'b1) begin
         errors++; $display("FAIL mid_first_word got %h/%b exp %h/1", gen_data, gen_valid, m_gen_word);
      end
      cycle(1, 0, 0, 0, 2'b11);
      checks++; if (gen_data !== m_gen_word) begin
         errors++; $display("FAIL mid_second_word got %h exp %h", gen_data, m_gen_word);
      end
   endtask

   task automatic test_prbs7_period();
      logic [7:0]  rec[300];
      logic [7:0]  mw[300];
      logic [63:0] w;
      bit          differs;
      gm_seed(2'b00);
      gen_en8 = 1;
      for (int n = 0; n < 300; n++) begin
         @(posedge clk);
         #1;
         w = gm_word(8);
         mw[n] = w[7:0];
         rec[n] = gen_data8;
         checks++; if (gen_data8 !== mw[n] || gen_valid8 !== 1'b1) begin
            errors++; $display("FAIL p7_word %0d got %h/%b exp %h/1", n, gen_data8, gen_valid8, mw[n]);
         end
         if (n >= 127) begin
            checks++; if (gen_data8 !== mw[n-127]) begin
               errors++; $display("FAIL p7_period word %0d got %h exp %h", n, gen_data8, mw[n-127]);
            end
         end
      end
      gen_en8 = 0;
      for (int p = 1; p < 127; p++) begin
         differs = 0;
         for (int n = 0; n + p < 300; n++) if (rec[n] !== rec[n+p]) differs = 1;
         checks++; if (!differs) begin
            errors++; $display("FAIL p7_short_period p %0d got repeat exp none", p);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lock();
      test_inject();
      test_clr_coincident();
      test_invert();
      test_mode_change();
      test_random();
      test_reset_mid();
      test_prbs7_period();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prbs_gen_chk.md
PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

Interface
REQ-001 Parameter P_DW, default 32, data word width (legal 8..64).
REQ-002 Parameter P_SEED, default 31'h0000A076, generator seed; low N bits used for PRBS-N.
REQ-003 Parameter P_LOCK_CNT, default 16, consecutive error-free words required to lock.
REQ-004 Parameter P_UNLOCK_CNT, default 4, consecutive errored words required to lose lock.
REQ-005 i_clk  input  1  clock.
REQ-006 i_rst  input  1  reset, asynchronous, active-high.
REQ-007 i_mode  input  2  polynomial: 00 PRBS7 (x^7+x^6+1), 01 PRBS15 (x^15+x^14+1), 10 PRBS23 (x^23+x^18+1), 11 PRBS31 (x^31+x^28+1).
REQ-008 i_gen_en  input  1  advance generator one word.
REQ-009 i_inj_err  input  1  invert bit 0 of the next generated word.
REQ-010 o_gen_data  output  P_DW  generated word.
REQ-011 o_gen_valid  output  1  o_gen_data valid.
REQ-012 i_chk_data  input  P_DW  received word.
REQ-013 i_chk_valid  input  1  i_chk_data valid.
REQ-014 i_clr  input  1  synchronous clear of error counter.
REQ-015 o_locked  output  1  checker locked.
REQ-016 o_err_word  output  1  one-cycle pulse per errored word while locked.
REQ-017 o_err_cnt  output  32  bit-error count while locked, saturating.

Function
REQ-018 Bit order: o_gen_data[P_DW-1] is the oldest bit of the word, bit 0 the newest; i_chk_data uses the same order.
REQ-019 Generator holds a 31-bit history register, bit 0 = newest bit; each new bit = hist[N-1] XOR hist[M-1] for PRBS-N taps (N,M); P_DW bits are produced per enabled cycle.
REQ-020 i_gen_en high: o_gen_data/o_gen_valid update on the next clock edge (latency 1); i_gen_en low: o_gen_valid=0, o_gen_data and history hold.
REQ-021 i_inj_err with i_gen_en high: output bit 0 inverted for that word only; history register is not affected; i_inj_err with i_gen_en low is ignored.
REQ-022 Seed load: history = P_SEED low N bits at reset and in the cycle after any i_mode change; a zero seed loads all-ones in the low N bits.
REQ-023 If the low N history bits are ever all-zero, the history is reloaded from seed on the next enabled cycle instead of advancing.
REQ-024 Checker is self-synchronising: it keeps the last 31 received bits across words; expected bit = recv[k-N] XOR recv[k-M]; mismatch vector computed per bit over each valid word.
REQ-025 Lock FSM states UNLOCK and LOCKED; UNLOCK -> LOCKED after P_LOCK_CNT consecutive valid words with zero mismatches; LOCKED -> UNLOCK after P_UNLOCK_CNT consecutive valid words with mismatches; an opposite-type word restarts the respective run counter; words with i_chk_valid low do not affect counters.
REQ-026 While LOCKED, each errored valid word adds popcount(mismatch) to o_err_cnt and pulses o_err_word one cycle after the word; o_err_cnt saturates at 32'hFFFFFFFF.
REQ-027 Note: one line bit error produces up to 3 checker mismatches (the bit plus its two tap echoes), possibly spread over successive words.
REQ-028 i_clr sets o_err_cnt to 0; i_clr coincident with an errored word: clear wins, that word is not counted.
REQ-029 i_mode change forces FSM to UNLOCK, zeroes run counters and checker history; o_err_cnt holds.

Reset
REQ-030 On i_rst: o_gen_data=0, o_gen_valid=0, o_locked=0, o_err_word=0, o_err_cnt=0, history=seed, checker history=0, FSM=UNLOCK; reset mid-operation aborts immediately with the same values.

Verification
REQ-031 P_DW=8, PRBS7, i_gen_en held 1 -> word n+127 equals word n for all n; no shorter repeat.
REQ-032 Loopback o_gen_data/o_gen_valid to checker, PRBS31, P_DW=32 -> o_locked rises after 16 error-free words, o_err_cnt stays 0.
REQ-033 Locked, one i_inj_err pulse, PRBS31 -> o_err_cnt=3, o_locked stays 1, o_err_word pulses 1 or 2 times.
REQ-034 Locked, invert all checker input for 4 consecutive words -> o_locked falls after the 4th; counts added only for words while locked.
REQ-035 Locked, change i_mode 11->01 -> o_locked=0 next cycle, relocks after 16 words of new sequence, o_err_cnt unchanged.
REQ-036 Assert i_rst mid-stream -> all outputs zero immediately; after release first word matches seed-derived golden model.
